// File: rtl/clk_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// Handshake: a divisor request is offered by holding div_load high for exactly
// one I_CLK cycle with div_in/mode_in valid in that same cycle; there is no
// ready signal because the divider always accepts (or rejects) it immediately,
// answering later with a one-cycle load_ack (applied) or load_err (rejected).
interface clk_divider_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             mode_in;
    logic             O_CLK;
    logic             O_TICK;
    logic [WIDTH-1:0] div_cur;
    logic             mode_cur;
    logic             load_ack;
    logic             load_err;

    // Requester side: drives enable and divisor requests, observes the divider.
    modport master (
        output en, div_in, div_load, mode_in,
        input  O_CLK, O_TICK, div_cur, mode_cur, load_ack, load_err
    );

    // Divider side.
    modport slave (
        input  en, div_in, div_load, mode_in,
        output O_CLK, O_TICK, div_cur, mode_cur, load_ack, load_err
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable clock divider with square/pulse output modes.
// A counter runs 0..div_cur-1; divisor/mode changes are held pending and only
// take effect at a period boundary so no output phase is ever truncated.
module clk_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input logic                I_CLK,
    input logic                rst,
    clk_divider_prog_if.slave  bus
);

    // Registered state
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] div_q,      div_d;
    logic             mode_q,     mode_d;
    logic             pend_q,     pend_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_mode_q, pend_mode_d;
    logic             clk_q,      clk_d;
    logic             tick_q,     tick_d;
    logic             ack_q,      ack_d;
    logic             err_q,      err_d;

    // Combinational helpers
    logic             wrap;
    logic             load_ok;
    logic             load_bad;
    logic             apply;
    logic [WIDTH-1:0] eff_div;
    logic             eff_mode;
    logic [WIDTH-1:0] half;

    // Next-state: counter advance, pending-load bookkeeping and output shaping.
    always_comb begin
        wrap     = bus.en && (cnt_q == (div_q - WIDTH'(1)));
        load_ok  = bus.div_load && (bus.div_in >= WIDTH'(2));
        load_bad = bus.div_load && (bus.div_in <  WIDTH'(2));
        // A request arriving on the wrap edge itself wins over an older one.
        apply    = wrap && (load_ok || pend_q);
        eff_div  = load_ok ? bus.div_in  : pend_div_q;
        eff_mode = load_ok ? bus.mode_in : pend_mode_q;

        div_d  = apply ? eff_div  : div_q;
        mode_d = apply ? eff_mode : mode_q;

        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        pend_mode_d = pend_mode_q;
        if (apply) begin
            pend_d = 1'b0;
        end else if (load_ok) begin
            pend_d      = 1'b1;
            pend_div_d  = bus.div_in;
            pend_mode_d = bus.mode_in;
        end

        // (div+1)>>1 written so it cannot overflow at the maximum divisor.
        half   = (div_d >> 1) + {{(WIDTH-1){1'b0}}, div_d[0]};
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (bus.en) begin
            cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
            clk_d  = mode_d ? (cnt_d == '0) : (cnt_d < half);
            tick_d = (cnt_d == '0);
        end

        ack_d = apply;
        err_d = load_bad;
    end

    // State register with synchronous reset; reset primes cnt so the first
    // enabled edge wraps and starts a fresh period.
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            cnt_q       <= WIDTH'(DEFAULT_DIV - 1);
            div_q       <= WIDTH'(DEFAULT_DIV);
            mode_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            pend_mode_q <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            pend_mode_q <= pend_mode_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign bus.O_CLK    = clk_q;
    assign bus.O_TICK   = tick_q;
    assign bus.div_cur  = div_q;
    assign bus.mode_cur = mode_q;
    assign bus.load_ack = ack_q;
    assign bus.load_err = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: default waveform, divisor/mode loads,
// rejected loads, enable freeze, same-edge load, overwrite, reset, max divisor.
module tb_clk_divider_prog;

    localparam int WIDTH = 8;

    // Clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    clk_divider_prog_if #(.WIDTH(WIDTH)) bus ();

    clk_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
        .I_CLK (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, sample shortly after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check period positions from..to-1 of a period of length len with hi high cycles.
    task automatic expect_cycles(input string tag, input int hi, input int len,
                                 input int from, input int to);
        for (int i = from; i < to; i++) begin
            step();
            check({tag, "_clk"},  {31'd0, bus.O_CLK},  {31'd0, (i < hi)});
            check({tag, "_tick"}, {31'd0, bus.O_TICK}, {31'd0, (i == 0)});
        end
        if (len < to) check({tag, "_len"}, 32'(to), 32'(len));
    endtask

    task automatic drive_load(input logic [WIDTH-1:0] d, input logic m);
        bus.div_load = 1'b1;
        bus.div_in   = d;
        bus.mode_in  = m;
    endtask

    task automatic clear_load();
        bus.div_load = 1'b0;
    endtask

    task automatic check_status(input string tag, input int dv, input int md,
                                input int ack, input int err);
        check({tag, "_div"},  32'(bus.div_cur),  32'(dv));
        check({tag, "_mode"}, {31'd0, bus.mode_cur}, 32'(md));
        check({tag, "_ack"},  {31'd0, bus.load_ack}, 32'(ack));
        check({tag, "_err"},  {31'd0, bus.load_err}, 32'(err));
    endtask

    // Stimulus
    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.div_in = '0;
        bus.div_load = 1'b0;
        bus.mode_in = 1'b0;
        step();
        step();
        check("rst_clk",  {31'd0, bus.O_CLK},  32'd0);
        check("rst_tick", {31'd0, bus.O_TICK}, 32'd0);
        check_status("rst", 10, 0, 0, 0);

        // Defaults: 5 high / 5 low, O_CLK rises on the first enabled edge
        rst = 1'b0;
        bus.en = 1'b1;
        expect_cycles("def", 5, 10, 0, 10);
        expect_cycles("def2", 5, 10, 0, 10);

        // Load 5 square mid-period; the 10-cycle period completes first
        expect_cycles("ld5a", 5, 10, 0, 3);
        drive_load(8'd5, 1'b0);
        expect_cycles("ld5b", 5, 10, 3, 4);
        clear_load();
        check_status("ld5_pend", 10, 0, 0, 0);
        expect_cycles("ld5c", 5, 10, 4, 10);
        step();
        check("ld5_clk0",  {31'd0, bus.O_CLK},  32'd1);
        check("ld5_tick0", {31'd0, bus.O_TICK}, 32'd1);
        check_status("ld5_app", 5, 0, 1, 0);
        expect_cycles("d5", 3, 5, 1, 5);
        expect_cycles("d5b", 3, 5, 0, 5);
        check_status("d5_after", 5, 0, 0, 0);

        // Rejected loads 1 and 0: two err pulses, nothing else changes
        drive_load(8'd1, 1'b1);
        expect_cycles("err1", 3, 5, 0, 1);
        check_status("err1", 5, 0, 0, 1);
        drive_load(8'd0, 1'b1);
        expect_cycles("err0", 3, 5, 1, 2);
        check_status("err0", 5, 0, 0, 1);
        clear_load();
        expect_cycles("err_c", 3, 5, 2, 3);
        check_status("err_clr", 5, 0, 0, 0);
        expect_cycles("err_d", 3, 5, 3, 5);
        expect_cycles("err_e", 3, 5, 0, 1);
        check_status("err_noapp", 5, 0, 0, 0);
        expect_cycles("err_f", 3, 5, 1, 5);

        // en low 7 cycles in the high phase: everything freezes
        expect_cycles("frz_a", 3, 5, 0, 2);
        bus.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("frz_clk",  {31'd0, bus.O_CLK},  32'd1);
            check("frz_tick", {31'd0, bus.O_TICK}, 32'd0);
        end
        bus.en = 1'b1;
        expect_cycles("frz_b", 3, 5, 2, 5);
        expect_cycles("frz_c", 3, 5, 0, 5);

        // Load 4 pulse mode mid-period
        expect_cycles("p4a", 3, 5, 0, 1);
        drive_load(8'd4, 1'b1);
        expect_cycles("p4b", 3, 5, 1, 2);
        clear_load();
        expect_cycles("p4c", 3, 5, 2, 5);
        step();
        check("p4_clk0",  {31'd0, bus.O_CLK},  32'd1);
        check("p4_tick0", {31'd0, bus.O_TICK}, 32'd1);
        check_status("p4_app", 4, 1, 1, 0);
        expect_cycles("p4d", 1, 4, 1, 4);
        expect_cycles("p4e", 1, 4, 0, 4);

        // Load on the wrap edge itself takes effect at that edge
        drive_load(8'd6, 1'b0);
        step();
        clear_load();
        check("same_clk0",  {31'd0, bus.O_CLK},  32'd1);
        check("same_tick0", {31'd0, bus.O_TICK}, 32'd1);
        check_status("same_app", 6, 0, 1, 0);
        expect_cycles("d6", 3, 6, 1, 6);

        // Two loads before the wrap: last one wins, single ack
        expect_cycles("ow_a", 3, 6, 0, 1);
        drive_load(8'd7, 1'b0);
        expect_cycles("ow_b", 3, 6, 1, 2);
        drive_load(8'd8, 1'b0);
        expect_cycles("ow_c", 3, 6, 2, 3);
        clear_load();
        check_status("ow_pend", 6, 0, 0, 0);
        expect_cycles("ow_d", 3, 6, 3, 6);
        step();
        check("ow_clk0", {31'd0, bus.O_CLK}, 32'd1);
        check_status("ow_app", 8, 0, 1, 0);
        step();
        check("ow_clk1", {31'd0, bus.O_CLK}, 32'd1);
        check_status("ow_once", 8, 0, 0, 0);
        expect_cycles("d8", 4, 8, 2, 8);

        // Reset mid-period with a load pending
        expect_cycles("rp_a", 4, 8, 0, 3);
        drive_load(8'd3, 1'b1);
        expect_cycles("rp_b", 4, 8, 3, 4);
        clear_load();
        rst = 1'b1;
        step();
        check("rp_clk",  {31'd0, bus.O_CLK},  32'd0);
        check("rp_tick", {31'd0, bus.O_TICK}, 32'd0);
        check_status("rp_rst", 10, 0, 0, 0);
        rst = 1'b0;
        step();
        check("rp_clk0",  {31'd0, bus.O_CLK},  32'd1);
        check("rp_tick0", {31'd0, bus.O_TICK}, 32'd1);
        check_status("rp_restart", 10, 0, 0, 0);
        expect_cycles("rp_c", 5, 10, 1, 10);
        expect_cycles("rp_d", 5, 10, 0, 1);
        check_status("rp_noack", 10, 0, 0, 0);
        expect_cycles("rp_e", 5, 10, 1, 10);

        // Maximum divisor 255: 128 high, 127 low, counter wraps cleanly
        drive_load(8'd255, 1'b0);
        step();
        clear_load();
        check("max_clk0", {31'd0, bus.O_CLK}, 32'd1);
        check_status("max_app", 255, 0, 1, 0);
        expect_cycles("max_a", 128, 255, 1, 255);
        expect_cycles("max_b", 128, 255, 0, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
